// File: rtl/phase_tracker_if.sv
// Bundle of the sample-write, query and result signals of phase_tracker.
// master: the surrounding datapath (drives samples/queries, consumes results).
// slave:  the phase tracker itself.
interface phase_tracker_if #(
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned PHASE_WIDTH = 24
);
    // CORDIC sample write stream (no backpressure)
    logic [PHASE_WIDTH-1:0] in_phase;
    logic [ADDR_WIDTH-2:0]  in_addr;
    logic                   in_valid;
    logic                   in_last;

    // Bin query request
    logic [ADDR_WIDTH-2:0]  q_bin;
    logic                   q_valid;
    logic                   q_ready;

    // Query result
    logic [PHASE_WIDTH-1:0] out_phase;
    logic [PHASE_WIDTH-1:0] out_phase_prev;
    logic [PHASE_WIDTH-1:0] out_delta;
    logic                   out_prev_valid;
    logic [ADDR_WIDTH-2:0]  out_bin;
    logic                   out_valid;
    logic                   out_ready;

    // Frame completion pulse
    logic                   frame_done;

    modport master (
        output in_phase, in_addr, in_valid, in_last,
        output q_bin, q_valid,
        input  q_ready,
        input  out_phase, out_phase_prev, out_delta, out_prev_valid, out_bin, out_valid,
        output out_ready,
        input  frame_done
    );

    modport slave (
        input  in_phase, in_addr, in_valid, in_last,
        input  q_bin, q_valid,
        output q_ready,
        output out_phase, out_phase_prev, out_delta, out_prev_valid, out_bin, out_valid,
        input  out_ready,
        output frame_done
    );
endinterface

// File: rtl/phase_tracker.sv
// Per-bin phase tracker between the CORDIC stage and the phase-vocoder accumulator.
// Frames of CORDIC phases land in a triple-buffered RAM (write / current / previous
// banks rotate by pointer, never copied). Any number of bin queries per frame are
// answered through a two-stage valid/ready pipeline with current phase, previous
// phase and the wrapped phase advance.
//
// Optional build macro PHASE_TRACKER_DEVIATION_EN: out_delta additionally removes the
// nominal per-hop advance of the bin, (bin << (PHASE_WIDTH+HOP_LOG2-ADDR_WIDTH)),
// whenever a previous frame exists.
module phase_tracker #(
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned PHASE_WIDTH = 24,
    parameter int unsigned HOP_LOG2    = 9
) (
    input  logic             clock,
    input  logic             reset,
    phase_tracker_if.slave   bus
);

    localparam int unsigned BinWidth = ADDR_WIDTH - 1;
    localparam int unsigned NumBins  = 2 ** BinWidth;
    localparam int unsigned MemDepth = 3 * NumBins;

    // The nominal-advance shift must not be negative.
    if (PHASE_WIDTH + HOP_LOG2 < ADDR_WIDTH) begin : g_param_check
        $error("phase_tracker: PHASE_WIDTH + HOP_LOG2 must be >= ADDR_WIDTH");
    end

    typedef enum logic [0:0] {
        StEmpty,
        StReady
    } state_e;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [1:0] wr_bank_q, cur_bank_q, prev_bank_q;
    logic [1:0] frames_seen_q;
    logic       frame_done_q;

    logic       rotate;
    logic       advance;
    logic       q_ready;
    logic       accept;

    // ------------------------------------------------------------------
    // Storage and pipeline
    // ------------------------------------------------------------------
    // Bank b occupies entries [b*NumBins, (b+1)*NumBins); index is {bank, bin}.
    logic [PHASE_WIDTH-1:0] mem_q [MemDepth];

    logic [PHASE_WIDTH-1:0] rd_cur_q;
    logic [PHASE_WIDTH-1:0] rd_prev_q;
    logic                   s1_valid_q;
    logic [BinWidth-1:0]    s1_bin_q;
    logic                   s1_prev_valid_q;

    logic [PHASE_WIDTH-1:0] prev_sel;
    logic [PHASE_WIDTH-1:0] delta_d;

    logic                   out_valid_q;
    logic [PHASE_WIDTH-1:0] out_phase_q;
    logic [PHASE_WIDTH-1:0] out_phase_prev_q;
    logic [PHASE_WIDTH-1:0] out_delta_q;
    logic                   out_prev_valid_q;
    logic [BinWidth-1:0]    out_bin_q;

    // An in_last without in_valid does not end a frame.
    assign rotate  = bus.in_valid && bus.in_last;
    // Both pipeline stages move together; a held result freezes the whole pipe.
    assign advance = !out_valid_q || bus.out_ready;
    assign accept  = bus.q_valid && q_ready;

    // State register: leaves EMPTY on the first completed frame and never returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and query-ready decode.
    always_comb begin
        state_d = state_q;
        q_ready = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (rotate) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                q_ready = advance;
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // Bank rotation: the retiring previous bank becomes the next write bank.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_bank_q   <= 2'd0;
            cur_bank_q  <= 2'd1;
            prev_bank_q <= 2'd2;
        end else if (rotate) begin
            prev_bank_q <= cur_bank_q;
            cur_bank_q  <= wr_bank_q;
            wr_bank_q   <= prev_bank_q;
        end
    end

    // Completed-frame count, saturating at two (enough to know a previous frame exists).
    always_ff @(posedge clock) begin
        if (reset) begin
            frames_seen_q <= 2'd0;
        end else if (rotate && (frames_seen_q != 2'd2)) begin
            frames_seen_q <= frames_seen_q + 2'd1;
        end
    end

    // Frame-done pulse, one cycle after the closing sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= rotate;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (bus.in_valid) begin
            mem_q[{wr_bank_q, bus.in_addr}] <= bus.in_phase;
        end
    end

    // RAM read ports: the bank pointers sampled here form the query's snapshot, so a
    // rotation in the same cycle is not seen. The write bank is never cur/prev, so
    // there is no read/write collision.
    always_ff @(posedge clock) begin
        if (accept) begin
            rd_cur_q  <= mem_q[{cur_bank_q, bus.q_bin}];
            rd_prev_q <= mem_q[{prev_bank_q, bus.q_bin}];
        end
    end

    // Stage 1: query bookkeeping alongside the RAM read.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q      <= 1'b0;
            s1_bin_q        <= '0;
            s1_prev_valid_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_bin_q        <= bus.q_bin;
                s1_prev_valid_q <= (frames_seen_q == 2'd2);
            end
        end
    end

`ifdef PHASE_TRACKER_DEVIATION_EN
    localparam int unsigned ExpShift = PHASE_WIDTH + HOP_LOG2 - ADDR_WIDTH;

    logic [PHASE_WIDTH-1:0] expected_d;
    logic [PHASE_WIDTH-1:0] s1_expected_q;

    // Nominal advance wraps naturally by truncation to PHASE_WIDTH.
    assign expected_d = PHASE_WIDTH'(bus.q_bin) << ExpShift;

    // Stage 1: nominal advance, already zeroed when no previous frame exists.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_expected_q <= '0;
        end else if (accept) begin
            s1_expected_q <= (frames_seen_q == 2'd2) ? expected_d : '0;
        end
    end

    // Stage 2 datapath: deviation from the nominal advance.
    always_comb begin
        prev_sel = s1_prev_valid_q ? rd_prev_q : '0;
        delta_d  = rd_cur_q - prev_sel - s1_expected_q;
    end
`else
    // Stage 2 datapath: plain wrapped phase difference.
    always_comb begin
        prev_sel = s1_prev_valid_q ? rd_prev_q : '0;
        delta_d  = rd_cur_q - prev_sel;
    end
`endif

    // Stage 2: output registers; data only changes when a real result moves in.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q      <= 1'b0;
            out_phase_q      <= '0;
            out_phase_prev_q <= '0;
            out_delta_q      <= '0;
            out_prev_valid_q <= 1'b0;
            out_bin_q        <= '0;
        end else if (advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_phase_q      <= rd_cur_q;
                out_phase_prev_q <= prev_sel;
                out_delta_q      <= delta_d;
                out_prev_valid_q <= s1_prev_valid_q;
                out_bin_q        <= s1_bin_q;
            end
        end
    end

    assign bus.q_ready        = q_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_phase      = out_phase_q;
    assign bus.out_phase_prev = out_phase_prev_q;
    assign bus.out_delta      = out_delta_q;
    assign bus.out_prev_valid = out_prev_valid_q;
    assign bus.out_bin        = out_bin_q;
    assign bus.frame_done     = frame_done_q;

endmodule

// File: tb/tb_phase_tracker.sv
// Bench for phase_tracker: directed scenarios plus randomized frames, checked against
// a frame-level model (current/previous frame arrays and a queue of expected results).
module tb_phase_tracker;

    localparam int unsigned AW  = 11;
    localparam int unsigned PW  = 24;
    localparam int unsigned HOP = 9;
    localparam int unsigned NB  = 1 << (AW - 1);

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    phase_tracker_if #(.ADDR_WIDTH(AW), .PHASE_WIDTH(PW)) bus ();

    phase_tracker #(
        .ADDR_WIDTH (AW),
        .PHASE_WIDTH(PW),
        .HOP_LOG2   (HOP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [AW-2:0] bin;
        logic [PW-1:0] ph;
        logic [PW-1:0] pp;
        logic [PW-1:0] dl;
        logic          pv;
        longint        due;
    } res_t;

    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;
    logic   last_acc;

    res_t          exp_q[$];
    logic [PW-1:0] m_wr   [NB];
    logic [PW-1:0] m_cur  [NB];
    logic [PW-1:0] m_prev [NB];
    int            m_frames;
    bit            force_en  [NB];
    logic [PW-1:0] force_val [NB];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Nominal advance removed from the delta when a previous frame exists.
    function automatic logic [PW-1:0] nominal(input int unsigned bin);
`ifdef PHASE_TRACKER_DEVIATION_EN
        logic [63:0] p;
        p = 64'(bin) * (64'd1 << (PW + HOP - AW));
        return p[PW-1:0];
`else
        return '0;
`endif
    endfunction

    // One clock: check outputs against the model, update the model with what the
    // edge consumes, then check the post-edge pulse / reset state.
    task automatic cycle();
        res_t          r;
        logic          fd_exp;
        logic          exp_ov;
        int unsigned   b;
        fd_exp   = 1'b0;
        last_acc = 1'b0;
        #1;
        if (!reset) begin
            exp_ov = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            chk("out_valid", bus.out_valid, exp_ov);
            if (bus.out_valid && exp_q.size() > 0) begin
                r = exp_q[0];
                chk("out_bin", bus.out_bin, r.bin);
                chk("out_phase", bus.out_phase, r.ph);
                chk("out_phase_prev", bus.out_phase_prev, r.pp);
                chk("out_delta", bus.out_delta, r.dl);
                chk("out_prev_valid", bus.out_prev_valid, r.pv);
                if (bus.out_ready) r = exp_q.pop_front();
            end
            if (m_frames == 0)
                chk("q_ready_empty", bus.q_ready, 0);
            else if (bus.out_ready)
                chk("q_ready_flow", bus.q_ready, 1);
            else if (exp_ov)
                chk("q_ready_stall", bus.q_ready, 0);

            last_acc = bus.q_valid && bus.q_ready;
            if (last_acc) begin
                b     = 32'(bus.q_bin);
                r.bin = bus.q_bin;
                r.ph  = m_cur[b];
                r.pv  = (m_frames >= 2);
                r.pp  = r.pv ? m_prev[b] : '0;
                r.dl  = r.ph - r.pp - (r.pv ? nominal(b) : '0);
                r.due = cyc + 2;
                exp_q.push_back(r);
            end
            if (bus.in_valid) begin
                m_wr[32'(bus.in_addr)] = bus.in_phase;
                if (bus.in_last) begin
                    m_prev = m_cur;
                    m_cur  = m_wr;
                    if (m_frames < 2) m_frames++;
                    fd_exp = 1'b1;
                end
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        chk("frame_done", bus.frame_done, fd_exp);
        if (reset) begin
            exp_q.delete();
            m_frames = 0;
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_q_ready", bus.q_ready, 0);
            chk("rst_out_phase", bus.out_phase, 0);
            chk("rst_out_phase_prev", bus.out_phase_prev, 0);
            chk("rst_out_delta", bus.out_delta, 0);
            chk("rst_out_prev_valid", bus.out_prev_valid, 0);
            chk("rst_out_bin", bus.out_bin, 0);
        end
    endtask

    // Write one full frame in bin order; optional gaps, random query traffic and a
    // query issued in the in_last cycle.
    task automatic run_frame(input int gap_pct, input bit rnd, input bit last_q,
                             input int unsigned last_q_bin);
        int unsigned b;
        bit          closing;
        b = 0;
        while (b < NB) begin
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            if (bus.in_valid) begin
                bus.in_addr  = (AW-1)'(b);
                bus.in_phase = force_en[b] ? force_val[b] : PW'($urandom);
                bus.in_last  = (b == NB - 1);
                b++;
            end else begin
                bus.in_addr  = (AW-1)'($urandom);
                bus.in_phase = PW'($urandom);
                bus.in_last  = 1'($urandom);
            end
            if (rnd) begin
                bus.q_valid   = 1'($urandom);
                bus.q_bin     = (AW-1)'($urandom);
                bus.out_ready = ($urandom_range(9) < 7);
            end
            closing = bus.in_valid && bus.in_last;
            if (last_q && closing) begin
                bus.q_valid   = 1'b1;
                bus.q_bin     = (AW-1)'(last_q_bin);
                bus.out_ready = 1'b1;
            end
            cycle();
            if (last_q && closing) chk("q_same_cycle_accept", last_acc, 1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < NB; i++) force_en[i] = 1'b0;
    endtask

    task automatic query(input int unsigned bin);
        int n;
        n           = 0;
        bus.q_valid = 1'b1;
        bus.q_bin   = (AW-1)'(bin);
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 20);
        chk("query_accept", last_acc, 1);
        bus.q_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n             = 0;
        bus.q_valid   = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic set_force(input int unsigned bin, input logic [PW-1:0] val);
        force_en[bin]  = 1'b1;
        force_val[bin] = val;
    endtask

    initial begin
        for (int i = 0; i < NB; i++) force_en[i] = 1'b0;
        m_frames      = 0;
        reset         = 1'b1;
        bus.in_phase  = '0;
        bus.in_addr   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.q_bin     = '0;
        bus.q_valid   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;

        // No frame yet: queries are refused.
        bus.q_valid = 1'b1;
        repeat (50) cycle();

        // A lone closing sample completes the first frame.
        bus.q_valid  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_addr  = (AW-1)'(NB - 1);
        bus.in_phase = PW'(24'h123456);
        bus.in_last  = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (2) cycle();

        // Fresh start for the data scenarios.
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;

        // Frame A: no previous frame.
        set_force(5, 24'h100000);
        set_force(4, 24'h000000);
        set_force(1, 24'h000000);
        run_frame(0, 1'b0, 1'b0, 0);
        query(5);
        query(4);
        drain();

        // Frame B: previous frame now valid.
        set_force(5, 24'h080000);
        set_force(4, 24'h400000);
        set_force(1, 24'h400000);
        run_frame(0, 1'b0, 1'b0, 0);
        query(5);
        query(4);
        query(1);
        drain();

        // Downstream stall with a pending query, then back-to-back bins 0..3.
        bus.out_ready = 1'b0;
        bus.q_valid   = 1'b1;
        repeat (10) begin
            bus.q_bin = (AW-1)'($urandom);
            cycle();
        end
        bus.out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bus.q_bin = (AW-1)'(b);
            cycle();
            chk("b2b_accept", last_acc, 1);
        end
        drain();

        // Frame C with a query in the closing cycle, then the same bin again.
        run_frame(0, 1'b0, 1'b1, 7);
        bus.q_valid = 1'b1;
        bus.q_bin   = (AW-1)'(7);
        cycle();
        chk("post_rotate_accept", last_acc, 1);
        drain();

        // Randomized frames with gaps, stray in_last and random query/ready traffic.
        repeat (3) run_frame(25, 1'b1, 1'b0, 0);
        drain();

        // Reset in the middle of a frame with queries in flight.
        bus.out_ready = 1'b1;
        bus.q_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.q_bin    = (AW-1)'($urandom);
            bus.in_valid = 1'b1;
            bus.in_addr  = (AW-1)'(i);
            bus.in_phase = PW'($urandom);
            cycle();
        end
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (5) cycle();
        bus.q_valid = 1'b0;
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
